tile_update_scheduler: RTL and testbench

Serialises tile-map modifications requested by in-level objects (coins, breakable blocks) onto the single write port of the level background map, and keeps the level's collection tally. Sits inside a level module, between the per-object touch detectors and the background tile store read by the VGA renderer and the Mario mover. Requests are latched, arbitrated round-robin, and committed one per handshake, so simultaneous touches are never lost.

---
 rtl/level_pkg.sv | 15 +
 rtl/tile_update_scheduler_rr_arbiter.sv | 31 +++
 rtl/tile_update_scheduler.sv | 120 ++++++++++++
 tb/tb_tile_update_scheduler.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/level_pkg.sv
// level_pkg: shared level constants (tile codes, map dimensions, coordinate widths)
// and the tile update scheduler state encoding.
package level_pkg;
    localparam int MAP_COLS = 17;
    localparam int MAP_ROWS = 12;
    localparam int COL_W    = 5;
    localparam int ROW_W    = 4;
    localparam int TILE_W   = 8;
    localparam logic [TILE_W-1:0] BDR = 8'd0;
    localparam logic [TILE_W-1:0] SKY = 8'd1;
    localparam logic [TILE_W-1:0] BLK = 8'd2;
    localparam logic [TILE_W-1:0] GND = 8'd3;
    localparam logic [TILE_W-1:0] TKN = 8'd4;
    typedef enum logic [1:0] {IDLE, WAIT_BLANK, WRITE, DONE} sched_state_t;
endpackage

// File: rtl/tile_update_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick over a request vector.
// Ports: req (request vector), pointer (highest-priority index),
//        grant (one-hot winner), idx (winner index), valid (any request).
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IW      = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      pointer,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      idx,
    output logic               valid
);
    logic [NUM_REQ-1:0] rot;

    // rot[k] is the request k positions past the pointer
    assign rot   = NUM_REQ'({req, req} >> pointer);
    assign valid = |req;

    // descending scan so the smallest distance from the pointer wins
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                idx   = IW'((int'(pointer) + k) % NUM_REQ);
                grant = NUM_REQ'(1) << ((int'(pointer) + k) % NUM_REQ);
            end
        end
    end
endmodule

// File: rtl/tile_update_scheduler.sv
// tile_update_scheduler: latches object touch requests, arbitrates them round-robin
// and commits one tile-map write per handshake, tallying collections.
// Ports: vga_clock/reset (sync active-high); req, req_x, req_y, req_tile per object;
//        vblank; wr_en/wr_x/wr_y/wr_tile/wr_ready map write port; grant pulse,
//        consumed sticky mask, collected count, level_complete.
// Config: define TILE_SCHED_BLANK_SYNC_EN to start writes only during vblank.
module tile_update_scheduler #(
    parameter int NUM_REQ      = 4,
    parameter int COL_W        = 5,
    parameter int ROW_W        = 4,
    parameter int TILE_W       = 8,
    parameter int TOTAL_TOKENS = 2,
    parameter int COUNT_W      = 8
) (
    input  logic                        vga_clock,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*COL_W-1:0]    req_x,
    input  logic [NUM_REQ*ROW_W-1:0]    req_y,
    input  logic [NUM_REQ*TILE_W-1:0]   req_tile,
    input  logic                        vblank,
    output logic                        wr_en,
    output logic [COL_W-1:0]            wr_x,
    output logic [ROW_W-1:0]            wr_y,
    output logic [TILE_W-1:0]           wr_tile,
    input  logic                        wr_ready,
    output logic [NUM_REQ-1:0]          grant,
    output logic [NUM_REQ-1:0]          consumed,
    output logic [COUNT_W-1:0]          collected,
    output logic                        level_complete
);
    import level_pkg::*;

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [COUNT_W-1:0] CMAX = '1;

    sched_state_t       state, state_nx;
    logic [NUM_REQ-1:0] req_q, pending, rise, arb_gnt, win_oh;
    logic [IW-1:0]      pointer, arb_idx, win;
    logic               arb_valid, pick, commit;
    logic [COUNT_W-1:0] coll_nx;

`ifndef TILE_SCHED_BLANK_SYNC_EN
    logic unused_vblank;
    assign unused_vblank = vblank;
`endif

    assign rise           = req & ~req_q & ~consumed & ~pending;
    assign wr_en          = state == WRITE;
    assign commit         = wr_en & wr_ready;
    assign coll_nx        = (collected == CMAX) ? collected : collected + 1'b1;
    assign level_complete = state == DONE;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
        .req     (pending),
        .pointer (pointer),
        .grant   (arb_gnt),
        .idx     (arb_idx),
        .valid   (arb_valid)
    );

    always_comb begin
        state_nx = state;
        pick     = 1'b0;
        case (state)
            IDLE: begin
                if (arb_valid) begin
                    pick = 1'b1;
`ifdef TILE_SCHED_BLANK_SYNC_EN
                    state_nx = WAIT_BLANK;
`else
                    state_nx = WRITE;
`endif
                end
            end
`ifdef TILE_SCHED_BLANK_SYNC_EN
            WAIT_BLANK: if (vblank) state_nx = WRITE;
`endif
            WRITE: if (wr_ready) state_nx = (coll_nx == COUNT_W'(TOTAL_TOKENS)) ? DONE : IDLE;
            DONE: state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge vga_clock) begin
        if (reset) begin
            state     <= IDLE;
            req_q     <= '0;
            pending   <= '0;
            consumed  <= '0;
            collected <= '0;
            pointer   <= '0;
            grant     <= '0;
            win       <= '0;
            win_oh    <= '0;
            wr_x      <= '0;
            wr_y      <= '0;
            wr_tile   <= '0;
        end else begin
            state   <= state_nx;
            req_q   <= req;
            // once the level is complete nothing further is queued
            pending <= (state_nx == DONE) ? '0 : (pending | rise) & ~(commit ? win_oh : '0);
            grant   <= commit ? win_oh : '0;
            if (commit) begin
                consumed  <= consumed | win_oh;
                collected <= coll_nx;
                pointer   <= (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
            end
            // write fields are frozen at pick time so they stay stable while wr_ready is low
            if (pick) begin
                win     <= arb_idx;
                win_oh  <= arb_gnt;
                wr_x    <= req_x[arb_idx*COL_W +: COL_W];
                wr_y    <= req_y[arb_idx*ROW_W +: ROW_W];
                wr_tile <= req_tile[arb_idx*TILE_W +: TILE_W];
            end
        end
    end
endmodule

// File: tb/tb_tile_update_scheduler.sv
// tb_tile_update_scheduler: scoreboard bench for tile_update_scheduler.
module tb_tile_update_scheduler;
    localparam int N = 4;
`ifdef TILE_SCHED_BLANK_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    typedef struct {
        logic [4:0] x;
        logic [3:0] y;
        logic [7:0] tile;
        int         idx;
    } exp_t;

    logic         clk = 0;
    logic         reset, vblank, wr_ready, wr_en, level_complete;
    logic [N-1:0] req, grant, consumed;
    logic [19:0]  req_x;
    logic [15:0]  req_y;
    logic [31:0]  req_tile;
    logic [4:0]   wr_x;
    logic [3:0]   wr_y;
    logic [7:0]   wr_tile;
    logic [7:0]   collected;

    logic [4:0] xs [N] = '{5'd6, 5'd7, 5'd12, 5'd16};
    logic [3:0] ys [N] = '{4'd6, 4'd3, 4'd9, 4'd11};
    logic [7:0] ts [N] = '{level_pkg::SKY, level_pkg::SKY, level_pkg::BLK, level_pkg::GND};

    exp_t         sb[$];
    logic [N-1:0] exp_grant = '0;
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    tile_update_scheduler dut (
        .vga_clock      (clk),
        .reset          (reset),
        .req            (req),
        .req_x          (req_x),
        .req_y          (req_y),
        .req_tile       (req_tile),
        .vblank         (vblank),
        .wr_en          (wr_en),
        .wr_x           (wr_x),
        .wr_y           (wr_y),
        .wr_tile        (wr_tile),
        .wr_ready       (wr_ready),
        .grant          (grant),
        .consumed       (consumed),
        .collected      (collected),
        .level_complete (level_complete)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input int i);
        sb.push_back('{xs[i], ys[i], ts[i], i});
    endtask

    task automatic wait_wr(output int n);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!wr_en && n < 20);
    endtask

    task automatic wait_coll(input int target, output int n);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (collected != 8'(target) && n < 20);
    endtask

    task automatic pulse_reset();
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
    endtask

    // commit monitor: a write accepted on the coming edge must match the scoreboard head
    // and produce a one-hot grant pulse on the following cycle
    always @(negedge clk) begin
        exp_t e;
        check("grant", 32'(grant), 32'(exp_grant));
        exp_grant = '0;
        if (wr_en && wr_ready && !reset) begin
            if (sb.size() == 0) begin
                check("spurious_write", 32'(wr_en), 32'd0);
            end else begin
                e = sb.pop_front();
                check("wr_x", 32'(wr_x), 32'(e.x));
                check("wr_y", 32'(wr_y), 32'(e.y));
                check("wr_tile", 32'(wr_tile), 32'(e.tile));
                exp_grant = N'(1) << e.idx;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        logic seen;
        reset = 1; req = '0; wr_ready = 1; vblank = 1;
        for (int i = 0; i < N; i++) begin
            req_x[i*5 +: 5]    = xs[i];
            req_y[i*4 +: 4]    = ys[i];
            req_tile[i*8 +: 8] = ts[i];
        end
        repeat (2) @(posedge clk);
        #1 reset = 0;
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_x", 32'(wr_x), 32'd0);
        check("rst_wr_y", 32'(wr_y), 32'd0);
        check("rst_wr_tile", 32'(wr_tile), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_consumed", 32'(consumed), 32'd0);
        check("rst_collected", 32'(collected), 32'd0);
        check("rst_level_complete", 32'(level_complete), 32'd0);

        // single request
        req[0] = 1; push(0);
        wait_wr(n);
        check("t1_latency", 32'(n), 32'(LAT));
        check("t1_wr_x", 32'(wr_x), 32'd6);
        check("t1_wr_y", 32'(wr_y), 32'd6);
        check("t1_wr_tile", 32'(wr_tile), 32'(level_pkg::SKY));
        @(posedge clk); #1;
        check("t1_wr_en_drop", 32'(wr_en), 32'd0);
        check("t1_grant", 32'(grant), 32'b0001);
        check("t1_collected", 32'(collected), 32'd1);
        check("t1_consumed", 32'(consumed), 32'b0001);
        check("t1_level_complete", 32'(level_complete), 32'd0);

        // held then toggled: a consumed object never writes again
        seen = 0;
        for (int i = 0; i < 110; i++) begin
            @(posedge clk); #1;
            req[0] = (i < 100) ? 1'b1 : i[0];
            seen |= wr_en;
        end
        req[0] = 0;
        check("t3_no_rewrite", 32'(seen), 32'd0);
        check("t3_collected", 32'(collected), 32'd1);

        // wr_ready low: write held stable until accepted; second token completes level
        wr_ready = 0; req[2] = 1; push(2);
        wait_wr(n);
        check("t4_wr_en", 32'(wr_en), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("t4_hold_wr_en", 32'(wr_en), 32'd1);
            check("t4_hold_wr_x", 32'(wr_x), 32'd12);
            check("t4_hold_wr_y", 32'(wr_y), 32'd9);
            check("t4_hold_wr_tile", 32'(wr_tile), 32'(level_pkg::BLK));
            check("t4_hold_collected", 32'(collected), 32'd1);
        end
        wr_ready = 1;
        @(posedge clk); #1;
        check("t4_collected", 32'(collected), 32'd2);
        check("t4_level_complete", 32'(level_complete), 32'd1);
        check("t4_consumed", 32'(consumed), 32'b0101);
        req[2] = 0;

        // rises after completion are ignored
        req[3] = 1;
        seen = 0;
        repeat (10) begin @(posedge clk); #1; seen |= wr_en; end
        check("done_no_write", 32'(seen), 32'd0);
        check("done_collected", 32'(collected), 32'd2);
        check("done_sticky", 32'(level_complete), 32'd1);
        req = '0;

        // simultaneous rises, pointer 0
        pulse_reset();
        check("t2_rst_collected", 32'(collected), 32'd0);
        check("t2_rst_level_complete", 32'(level_complete), 32'd0);
        req[1:0] = 2'b11; push(0); push(1);
        wait_coll(1, n);
        check("t2_first", 32'(collected), 32'd1);
        check("t2_first_consumed", 32'(consumed), 32'b0001);
        wait_coll(2, n);
        check("t2_gap", 32'(n), 32'(LAT));
        check("t2_consumed", 32'(consumed), 32'b0011);
        check("t2_level_complete", 32'(level_complete), 32'd1);
        req = '0;

        // reset mid-write drops the write; a still-high request starts fresh
        pulse_reset();
        wr_ready = 0; req[1] = 1; push(1);
        wait_wr(n);
        check("t5_in_write", 32'(wr_en), 32'd1);
        pulse_reset();
        check("t5_wr_en", 32'(wr_en), 32'd0);
        check("t5_collected", 32'(collected), 32'd0);
        check("t5_consumed", 32'(consumed), 32'd0);
        wr_ready = 1;
        wait_wr(n);
        check("t5_latency", 32'(n), 32'(LAT));
        @(posedge clk); #1;
        check("t5_fresh_collected", 32'(collected), 32'd1);
        check("t5_fresh_consumed", 32'(consumed), 32'b0010);

        // pointer now 2: req3 is closer than req0; req0 is dropped when the level completes
        req[0] = 1; req[3] = 1; push(3);
        wait_coll(2, n);
        check("rr_collected", 32'(collected), 32'd2);
        check("rr_consumed", 32'(consumed), 32'b1010);
        seen = 0;
        repeat (10) begin @(posedge clk); #1; seen |= wr_en; end
        check("rr_no_loser_write", 32'(seen), 32'd0);
        req = '0;

`ifdef TILE_SCHED_BLANK_SYNC_EN
        pulse_reset();
        vblank = 0; req[2] = 1; push(2);
        seen = 0;
        repeat (10) begin @(posedge clk); #1; seen |= wr_en; end
        check("vb_wait", 32'(seen), 32'd0);
        vblank = 1;
        @(posedge clk); #1;
        check("vb_wr_en", 32'(wr_en), 32'd1);
        @(posedge clk); #1;
        check("vb_collected", 32'(collected), 32'd1);
        req = '0;
`endif

        repeat (3) @(posedge clk);
        #1 check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
